// File: rtl/aq_ifu_ras_pkg.sv
// Shared IFU definitions for the return address stack.
// Holds widths, the per-cycle operation encoding and its priority decode.
package aq_ifu_ras_pkg;

  localparam int unsigned AQ_IFU_ADDR_W     = 40;
  localparam int unsigned AQ_IFU_RAS_DEPTH  = 4;
  localparam int unsigned AQ_IFU_RAS_PTR_W  = $clog2(AQ_IFU_RAS_DEPTH);
  localparam int unsigned AQ_IFU_RAS_CNT_W  = AQ_IFU_RAS_PTR_W + 1;

  typedef enum logic [2:0] {
    RAS_OP_NONE,
    RAS_OP_FLUSH,
    RAS_OP_REPLACE,
    RAS_OP_PUSH,
    RAS_OP_POP
  } ras_op_e;

  // Priority: flush > push+pop > push > pop; pop/replace need a non-empty stack.
  function automatic ras_op_e ras_op_decode(input logic flush,
                                            input logic push,
                                            input logic pop,
                                            input logic nonempty);
    ras_op_e op;
    op = RAS_OP_NONE;
    if (flush)                       op = RAS_OP_FLUSH;
    else if (push && pop && nonempty) op = RAS_OP_REPLACE;
    else if (push)                   op = RAS_OP_PUSH;
    else if (pop && nonempty)        op = RAS_OP_POP;
    return op;
  endfunction

endpackage

// File: rtl/aq_ifu_ras_if.sv
// Pre-decoder / IFU side of the return address stack.
interface aq_ifu_ras_if
  import aq_ifu_ras_pkg::*;
#(
  parameter int unsigned ADDR_W = AQ_IFU_ADDR_W,
  parameter int unsigned CNT_W  = AQ_IFU_RAS_CNT_W
);

  logic              ras_push_vld;
  logic [ADDR_W-1:0] ras_push_addr;
  logic              ras_pop_vld;
  logic              ras_flush;
  logic [ADDR_W-1:0] ras_pred_target;
  logic              ras_pred_vld;
  logic              ras_full;
  logic [CNT_W-1:0]  ras_cnt;

  modport master (
    output ras_push_vld, ras_push_addr, ras_pop_vld, ras_flush,
    input  ras_pred_target, ras_pred_vld, ras_full, ras_cnt
  );

  modport slave (
    input  ras_push_vld, ras_push_addr, ras_pop_vld, ras_flush,
    output ras_pred_target, ras_pred_vld, ras_full, ras_cnt
  );

endinterface

// File: rtl/aq_ifu_ras.sv
// Circular return address stack: pushes on link, pops on return, never stalls.
// On overflow the oldest entry is overwritten; flush empties without clearing data.
module aq_ifu_ras
  import aq_ifu_ras_pkg::*;
#(
  parameter int unsigned DEPTH  = AQ_IFU_RAS_DEPTH,
  parameter int unsigned ADDR_W = AQ_IFU_ADDR_W
) (
  input  logic         forever_cpuclk,
  input  logic         cpurst_b,
  aq_ifu_ras_if.slave  ras
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [ADDR_W-1:0] entry_q [DEPTH];
  logic [ADDR_W-1:0] entry_d [DEPTH];
  logic [PTR_W-1:0]  tp_q, tp_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [PTR_W-1:0]  top_idx;
  logic              nonempty;
  logic              full;
  ras_op_e           op;

  assign top_idx  = tp_q - PTR_W'(1);
  assign nonempty = (cnt_q != '0);
  assign full     = (cnt_q == CNT_W'(DEPTH));
  assign op       = ras_op_decode(ras.ras_flush, ras.ras_push_vld,
                                  ras.ras_pop_vld, nonempty);

  // Next-state: pointer wraps naturally modulo DEPTH; count saturates at DEPTH.
  always_comb begin
    entry_d = entry_q;
    tp_d    = tp_q;
    cnt_d   = cnt_q;
    unique case (op)
      RAS_OP_FLUSH: begin
        tp_d  = '0;
        cnt_d = '0;
      end
      RAS_OP_REPLACE: begin
        entry_d[top_idx] = ras.ras_push_addr;
      end
      RAS_OP_PUSH: begin
        entry_d[tp_q] = ras.ras_push_addr;
        tp_d          = tp_q + PTR_W'(1);
        cnt_d         = full ? cnt_q : cnt_q + CNT_W'(1);
      end
      RAS_OP_POP: begin
        tp_d  = top_idx;
        cnt_d = cnt_q - CNT_W'(1);
      end
      default: begin
      end
    endcase
  end

  always_ff @(posedge forever_cpuclk) begin
    if (!cpurst_b) begin
      entry_q <= '{default: '0};
      tp_q    <= '0;
      cnt_q   <= '0;
    end else begin
      entry_q <= entry_d;
      tp_q    <= tp_d;
      cnt_q   <= cnt_d;
    end
  end

  assign ras.ras_pred_target = nonempty ? entry_q[top_idx] : '0;
  assign ras.ras_pred_vld    = nonempty;
  assign ras.ras_full        = full;
  assign ras.ras_cnt         = cnt_q;

endmodule

// File: tb/tb_aq_ifu_ras.sv
// Directed vector bench for aq_ifu_ras (DEPTH = 4, ADDR_W = 40).
module tb_aq_ifu_ras;
  import aq_ifu_ras_pkg::*;

  logic clk;
  logic rst_b;

  aq_ifu_ras_if ras_if ();

  aq_ifu_ras dut (
    .forever_cpuclk (clk),
    .cpurst_b       (rst_b),
    .ras            (ras_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rst_b;
    logic        push;
    logic [39:0] addr;
    logic        pop;
    logic        flush;
    logic        exp_vld;
    logic [39:0] exp_tgt;
    logic        exp_full;
    logic [2:0]  exp_cnt;
  } vec_t;

  localparam int NV = 32;
  vec_t vecs [NV];

  int n_chk  = 0;
  int n_pass = 0;

  function automatic vec_t mk(logic r, logic pu, logic [39:0] a, logic po, logic fl,
                              logic ev, logic [39:0] et, logic ef, logic [2:0] ec);
    vec_t v;
    v.rst_b = r;  v.push = pu; v.addr = a; v.pop = po; v.flush = fl;
    v.exp_vld = ev; v.exp_tgt = et; v.exp_full = ef; v.exp_cnt = ec;
    return v;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s actual=%h expected=%h", name, act, exp);
  endtask

  task automatic chk_outs(input string tag, input logic ev, input logic [39:0] et,
                          input logic ef, input logic [2:0] ec);
    chk({tag, ".vld"},  64'(ras_if.ras_pred_vld),    64'(ev));
    chk({tag, ".tgt"},  64'(ras_if.ras_pred_target), 64'(et));
    chk({tag, ".full"}, 64'(ras_if.ras_full),        64'(ef));
    chk({tag, ".cnt"},  64'(ras_if.ras_cnt),         64'(ec));
  endtask

  task automatic drive(input logic r, input logic pu, input logic [39:0] a,
                       input logic po, input logic fl);
    rst_b                = r;
    ras_if.ras_push_vld  = pu;
    ras_if.ras_push_addr = a;
    ras_if.ras_pop_vld   = po;
    ras_if.ras_flush     = fl;
  endtask

  initial begin
    //               rst push addr        pop fl   vld tgt         full cnt
    vecs[0]  = mk(0, 0, 40'h0,      0, 0,  0, 40'h0,     0, 3'd0);
    vecs[1]  = mk(1, 1, 40'h100,    0, 0,  1, 40'h100,   0, 3'd1);
    vecs[2]  = mk(1, 1, 40'h204,    0, 0,  1, 40'h204,   0, 3'd2);
    vecs[3]  = mk(1, 1, 40'h308,    0, 0,  1, 40'h308,   0, 3'd3);
    vecs[4]  = mk(1, 0, 40'h0,      1, 0,  1, 40'h204,   0, 3'd2);
    vecs[5]  = mk(1, 0, 40'h0,      1, 0,  1, 40'h100,   0, 3'd1);
    vecs[6]  = mk(1, 0, 40'h0,      1, 0,  0, 40'h0,     0, 3'd0);
    vecs[7]  = mk(1, 0, 40'h0,      1, 0,  0, 40'h0,     0, 3'd0);
    // overflow: 0x10 gets overwritten by 0x50
    vecs[8]  = mk(1, 1, 40'h10,     0, 0,  1, 40'h10,    0, 3'd1);
    vecs[9]  = mk(1, 1, 40'h20,     0, 0,  1, 40'h20,    0, 3'd2);
    vecs[10] = mk(1, 1, 40'h30,     0, 0,  1, 40'h30,    0, 3'd3);
    vecs[11] = mk(1, 1, 40'h40,     0, 0,  1, 40'h40,    1, 3'd4);
    vecs[12] = mk(1, 1, 40'h50,     0, 0,  1, 40'h50,    1, 3'd4);
    vecs[13] = mk(1, 0, 40'h0,      1, 0,  1, 40'h40,    0, 3'd3);
    vecs[14] = mk(1, 0, 40'h0,      1, 0,  1, 40'h30,    0, 3'd2);
    vecs[15] = mk(1, 0, 40'h0,      1, 0,  1, 40'h20,    0, 3'd1);
    vecs[16] = mk(1, 0, 40'h0,      1, 0,  0, 40'h0,     0, 3'd0);
    // simultaneous push+pop
    vecs[17] = mk(1, 1, 40'h100,    0, 0,  1, 40'h100,   0, 3'd1);
    vecs[18] = mk(1, 1, 40'h200,    0, 0,  1, 40'h200,   0, 3'd2);
    vecs[19] = mk(1, 1, 40'h300,    1, 0,  1, 40'h300,   0, 3'd2);
    vecs[20] = mk(1, 0, 40'h0,      1, 0,  1, 40'h100,   0, 3'd1);
    vecs[21] = mk(1, 0, 40'h0,      1, 0,  0, 40'h0,     0, 3'd0);
    vecs[22] = mk(1, 1, 40'h300,    1, 0,  1, 40'h300,   0, 3'd1);
    vecs[23] = mk(1, 0, 40'h0,      1, 0,  0, 40'h0,     0, 3'd0);
    // flush beats a same-cycle push
    vecs[24] = mk(1, 1, 40'h1,      0, 0,  1, 40'h1,     0, 3'd1);
    vecs[25] = mk(1, 1, 40'h2,      0, 0,  1, 40'h2,     0, 3'd2);
    vecs[26] = mk(1, 1, 40'h3,      0, 0,  1, 40'h3,     0, 3'd3);
    vecs[27] = mk(1, 1, 40'h500,    0, 1,  0, 40'h0,     0, 3'd0);
    vecs[28] = mk(1, 1, 40'h600,    0, 0,  1, 40'h600,   0, 3'd1);
    // synchronous reset with cnt = 2 and a push active
    vecs[29] = mk(1, 1, 40'h700,    0, 0,  1, 40'h700,   0, 3'd2);
    vecs[30] = mk(0, 1, 40'h800,    0, 0,  0, 40'h0,     0, 3'd0);
    vecs[31] = mk(1, 1, 40'hab_cdef_0123, 0, 0, 1, 40'hab_cdef_0123, 0, 3'd1);

    drive(1'b0, 1'b0, 40'h0, 1'b0, 1'b0);
    for (int i = 0; i < NV; i++) begin
      drive(vecs[i].rst_b, vecs[i].push, vecs[i].addr, vecs[i].pop, vecs[i].flush);
      @(posedge clk);
      #1;
      chk_outs($sformatf("v%0d", i), vecs[i].exp_vld, vecs[i].exp_tgt,
               vecs[i].exp_full, vecs[i].exp_cnt);
    end

    // Reset pulsed low strictly between edges must not disturb state.
    drive(1'b1, 1'b0, 40'h0, 1'b0, 1'b0);
    #2 rst_b = 1'b0;
    #2 rst_b = 1'b1;
    chk_outs("glitch_pre", 1'b1, 40'hab_cdef_0123, 1'b0, 3'd1);
    @(posedge clk);
    #1;
    chk_outs("glitch_post", 1'b1, 40'hab_cdef_0123, 1'b0, 3'd1);

    // Full stack: push+pop replaces the top and keeps cnt at DEPTH.
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 1'b1, 40'(32'h1000 + i), 1'b0, 1'b0);
      @(posedge clk);
      #1;
    end
    chk_outs("fill", 1'b1, 40'h1002, 1'b1, 3'd4);
    drive(1'b1, 1'b1, 40'hfeed, 1'b1, 1'b0);
    @(posedge clk);
    #1;
    chk_outs("full_pushpop", 1'b1, 40'hfeed, 1'b1, 3'd4);
    drive(1'b1, 1'b0, 40'h0, 1'b1, 1'b0);
    @(posedge clk);
    #1;
    chk_outs("full_pop", 1'b1, 40'h1001, 1'b0, 3'd3);

    // Flush with pop pending leaves an empty stack.
    drive(1'b1, 1'b0, 40'h0, 1'b1, 1'b1);
    @(posedge clk);
    #1;
    chk_outs("flush_pop", 1'b0, 40'h0, 1'b0, 3'd0);
    drive(1'b1, 1'b0, 40'h0, 1'b0, 1'b0);
    @(posedge clk);
    #1;

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/aq_ifu_ras.md
Name: aq_ifu_ras

Overview:
- Return address stack in the IFU prediction path, directly downstream of the pre-decoder.
- Pushes return addresses when the pre-decoder flags link instructions (JAL/JALR/C.JALR writing x1).
- Pops on return instructions (JALR x1 / C.JR x1) and supplies the predicted return target to the IFU change-of-flow mux.
- Circular storage: on overflow the oldest entry is overwritten; no stall is ever generated.

Parameters:
- DEPTH, 4, number of entries; power of two, >= 2.
- ADDR_W, 40, return address width; matches the 40-bit prediction immediate/PC width.

Ports:
- forever_cpuclk  input  1  core clock.
- cpurst_b  input  1  synchronous, active-low reset.
- ras_push_vld  input  1  link instruction predicted this cycle (qualified pred_link_vld0/1 from the pre-decoder).
- ras_push_addr  input  ADDR_W  return address to push (PC + 2 or PC + 4, computed upstream).
- ras_pop_vld  input  1  return instruction predicted this cycle (qualified pred_ret_vld0/1).
- ras_flush  input  1  pipeline flush or mispredict; empties the stack.
- ras_pred_target  output  ADDR_W  top-of-stack address.
- ras_pred_vld  output  1  stack non-empty; ras_pred_target is usable.
- ras_full  output  1  count == DEPTH.
- ras_cnt  output  log2(DEPTH)+1  number of valid entries.

Behaviour:
- Clock and reset: one clock, forever_cpuclk. cpurst_b is synchronous and active-low. The reset is sampled only on the rising edge.
- Reset state: top pointer tp = 0, cnt = 0, all entries = 0. Outputs after reset: ras_pred_vld = 0, ras_pred_target = 0, ras_full = 0, ras_cnt = 0.
- State: entry[DEPTH], tp (log2 DEPTH bits, index of the next free slot, wraps modulo DEPTH), cnt (0..DEPTH).
- Top index is tp-1 modulo DEPTH.
- Outputs are combinational from the registers. Updates become visible the cycle after the event; there is no same-cycle bypass.
  - ras_pred_target = entry[tp-1] when cnt != 0, else 0.
  - ras_pred_vld = (cnt != 0).
  - ras_full = (cnt == DEPTH).
- Per-cycle update priority: reset > flush > push+pop > push > pop.
- flush: tp <= 0, cnt <= 0. Entries are kept (stale, invisible). A push or pop in the same cycle is ignored.
- push only:
  - entry[tp] <= ras_push_addr; tp <= tp+1.
  - cnt <= min(cnt+1, DEPTH).
  - When full, this overwrites the oldest entry and cnt stays DEPTH.
- pop only, cnt > 0: tp <= tp-1; cnt <= cnt-1.
- pop only, cnt == 0: no state change. ras_pred_vld stays 0, so the IFU falls back to its non-RAS target.
- push and pop together (a return followed by a link, treated as pop-then-push):
  - cnt > 0: entry[tp-1] <= ras_push_addr; tp and cnt unchanged.
  - cnt == 0: behaves as push only.
- Wrap-around: tp increments from DEPTH-1 to 0 and decrements from 0 to DEPTH-1. cnt never exceeds DEPTH and never goes below 0.
- Reset mid-operation: all state returns to reset values on that edge, regardless of push/pop/flush.
- Inputs are assumed already qualified by instruction valid and IFU accept. The block adds no further gating.
- No X propagation: entries are reset, so ras_pred_target is never X.

Decomposition:
- Shared IFU package holds:
  - AQ_IFU_ADDR_W = 40
  - AQ_IFU_RAS_DEPTH = 4
  - the derived pointer width: clog2 of depth
  - the count width: pointer width + 1
- No sub-module: the storage array, pointer and counter form one flat sequential block of about 150–200 lines.

Test Plan:
- Reset, then three pushes of 0x100, 0x204, 0x308 on consecutive cycles:
  - cycle after each push: target = pushed address, ras_pred_vld = 1.
  - final ras_cnt = 3, ras_full = 0.
- From that state, three pops: targets seen in turn are 0x204, then 0x100, then ras_pred_vld = 0 with target 0. A fourth pop on the empty stack leaves cnt = 0 and tp unchanged.
- Overflow, DEPTH = 4: push 0x10, 0x20, 0x30, 0x40, 0x50.
  - cnt = 4, ras_full = 1, target = 0x50.
  - Four pops then give 0x40, 0x30, 0x20, then empty; 0x10 is lost.
- Simultaneous push+pop with stack [0x100, 0x200], push 0x300: cnt stays 2, target = 0x300; one pop then gives target 0x100. The same stimulus on an empty stack gives cnt = 1, target = 0x300.
- Flush with stack cnt = 3 and push 0x500 in the same cycle: next cycle cnt = 0, ras_pred_vld = 0. A following push of 0x600 gives cnt = 1, target = 0x600.
- Synchronous reset:
  - cpurst_b low for one cycle with cnt = 2 and a push active: next cycle all outputs 0.
  - cpurst_b toggled low between clock edges only: no state change.
